pipeexe_md: RTL and testbench
=============================

PIPEEXE_MD -- requirements
Module: pipeexe_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values are even and at least 8.
REQ-002 SHALL have parameter RW, default 5, meaning register-number width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ein_valid, input, 1, meaning an instruction is present in EX.
REQ-006 SHALL have ports ealuc (input, 4), ealuimm (input, 1), eshift (input, 1) and ejal (input, 1), meaning ALU control, B-select-imm, A-select-imm and jal respectively.
REQ-007 SHALL have port emd_op, input, 3, meaning the multiply/divide opcode (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO).
REQ-008 SHALL have ports ea, eb, eimm and epc4, input, XLEN each, meaning the operands and PC+4.
REQ-009 SHALL have ports ern0 (input, RW), the destination register, and ewreg (input, 1), the register write enable.
REQ-010 SHALL have port estall, output, 1, meaning hold IF/ID/EX this cycle.
REQ-011 SHALL have ports mvalid (output, 1), mwreg (output, 1), mrn (output, RW) and malu (output, XLEN), which form the registered EX/MEM outputs.
REQ-012 SHALL have port md_busy, output, 1, meaning the mul/div unit is not idle.

Function
REQ-013 SHALL compute the ALU path combinationally: opa is eimm when eshift is set, else ea; opb is eimm when ealuimm is set, else eb; alu_out = ALU(opa, opb, ealuc).
REQ-014 SHALL select the EX result: epc4+4 (mod 2^XLEN) if ejal; else HI if MFHI; else LO if MFLO; else alu_out.
REQ-015 SHALL form the destination: ern = ern0 | {RW{ejal}}.
REQ-016 SHALL assert estall combinationally when ein_valid, md_busy, and emd_op is one of MULT/MULTU/DIV/DIVU/MFHI/MFLO; all other ops SHALL proceed while the unit is busy.
REQ-017 On each edge with estall=0, the stage SHALL load mvalid<=ein_valid, mwreg<=ein_valid&ewreg, mrn<=ern and malu<=result; latency is 1 cycle.
REQ-018 On each edge with estall=1, the stage SHALL load a bubble: mvalid<=0, mwreg<=0; mrn and malu SHALL hold.
REQ-019 MULT/MULTU/DIV/DIVU SHALL start the unit on an edge with ein_valid and estall=0, latching ea and eb; the instruction itself SHALL pass to MEM.
REQ-020 The unit FSM SHALL have three states, IDLE -> RUN -> FIX -> IDLE.
REQ-021 In RUN, the unit SHALL take exactly XLEN cycles, one bit per cycle (shift-add multiply, restoring divide on magnitudes), followed by one cycle in FIX (sign fix-up, HI/LO write).
REQ-022 md_busy SHALL be high in RUN and FIX, i.e. for exactly XLEN+1 cycles after the start edge.
REQ-023 HI and LO SHALL be updated at the FIX->IDLE edge; a dependent MFHI/MFLO is unstalled in the following cycle.
REQ-024 Multiply SHALL produce HI:LO = 2*XLEN-bit product, signed for MULT and unsigned for MULTU.
REQ-025 Divide SHALL produce LO = quotient truncated toward zero and HI = remainder with the sign of the dividend.
REQ-026 Divide by zero SHALL produce LO = all ones and HI = dividend, with no trap.
REQ-027 Signed minimum / -1 SHALL produce LO = minimum and HI = 0.
REQ-028 A new start SHALL NOT be accepted while the unit is busy, since estall holds it back.

Reset
REQ-029 While resetn is low, the block SHALL asynchronously force mvalid=0, mwreg=0, mrn=0, malu=0, HI=0 and LO=0, with the FSM in IDLE, the counter at 0 and md_busy=0.
REQ-030 Reset asserted during RUN or FIX SHALL abort the operation, leaving no HI/LO update.

Structure
REQ-031 The shared package SHALL hold the emd_op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6), the FSM state encoding and the ealuc constants.
REQ-032 The existing ALU SHALL be instantiated unchanged; the sub-module pipemdu SHALL hold the iterative mul/div FSM, the counter and HI/LO.

Verification (XLEN=32)
REQ-033 A bench SHALL drive ea=5, eimm=7, ealuimm=1, ealuc=ADD, ern0=8, ewreg=1 and check that the next edge gives malu=12, mrn=8, mwreg=1, mvalid=1.
REQ-034 A bench SHALL drive ejal=1, epc4=0x100, ern0=0 and check malu=0x104, mrn=31.
REQ-035 A bench SHALL issue MULT -3*5 then MFLO and check estall high 33 cycles, then malu=0xFFFFFFF1; a following MFHI SHALL give malu=0xFFFFFFFF.
REQ-036 A bench SHALL check that DIV -7/2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF, and that DIVU 9/0 gives LO=0xFFFFFFFF, HI=9.
REQ-037 A bench SHALL check that an independent ADD issued during md_busy gives no stall and a correct malu next edge.
REQ-038 A bench SHALL pulse resetn low 10 cycles into a DIV and check that md_busy=0, mvalid=0 and HI=LO=0 immediately, before any clock edge.

Source files
------------

// File: rtl/pipeexe_md_pkg.sv
// Shared encodings for the EX stage with the iterative multiply/divide unit:
// mul/div opcodes, unit FSM states and ALU control codes.
package pipeexe_md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    function automatic logic md_is_start(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Any op that either starts the unit or reads HI/LO must wait while it is busy.
    function automatic logic md_is_hazard(input logic [2:0] op);
        return md_is_start(op) || (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/pipealu.sv
// Combinational ALU; shifts take the amount from a and shift b.
module pipealu
    import pipeexe_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      aluc,
    output logic [XLEN-1:0] r
);

    localparam int SHW = $clog2(XLEN);

    always_comb begin
        r = a + b;
        case (aluc)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_LUI: r = b << (XLEN / 2);
            ALU_SLL: r = b << a[SHW-1:0];
            ALU_SRL: r = b >> a[SHW-1:0];
            ALU_SRA: r = $signed(b) >>> a[SHW-1:0];
            default: r = a + b;
        endcase
    end

endmodule

// File: rtl/pipemdu.sv
// Iterative multiply/divide unit: XLEN one-bit steps on magnitudes in RUN,
// then one FIX cycle that applies signs and writes HI/LO.
module pipemdu
    import pipeexe_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mq_q, mq_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;

    logic            is_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, mul_add;
    logic [XLEN:0]   mul_sum, div_sh;
    logic [XLEN+1:0] div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = is_signed & a[XLEN-1];
        b_neg     = is_signed & b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        mul_add   = mq_q[0] ? dvs_q : {XLEN{1'b0}};
        mul_sum   = {1'b0, acc_q} + {1'b0, mul_add};
        div_sh    = {acc_q, mq_q[XLEN-1]};
        div_diff  = {1'b0, div_sh} - {2'b00, dvs_q};
        prod      = {acc_q, mq_q};
        prod_fix  = neg_q ? -prod : prod;

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        dvs_d    = dvs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d  = MD_RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mq_d     = a_mag;
                    dvs_d    = b_mag;
                    is_div_d = (op == MD_DIV) || (op == MD_DIVU);
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dz_d     = (b == '0);
                end
            end
            MD_RUN: begin
                if (is_div_q) begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!div_diff[XLEN+1]) begin
                        acc_d = div_diff[XLEN-1:0];
                        mq_d  = {mq_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = div_sh[XLEN-1:0];
                        mq_d  = {mq_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[XLEN:1];
                    mq_d  = {mul_sum[0], mq_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = MD_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (is_div_q) begin
                    lo_d = dz_q ? {XLEN{1'b1}} : (neg_q ? -mq_q : mq_q);
                    hi_d = rneg_q ? -acc_q : acc_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            dvs_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            dvs_q    <= dvs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
        end
    end

    assign busy = (state_q == MD_RUN) || (state_q == MD_FIX);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/pipeexe_md.sv
// EX stage with ALU, HI/LO access and an iterative mul/div unit, feeding the
// registered EX/MEM boundary; mul/div hazards stall IF/ID/EX.
module pipeexe_md
    import pipeexe_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            ein_valid,
    input  logic [3:0]      ealuc,
    input  logic            ealuimm,
    input  logic            eshift,
    input  logic            ejal,
    input  logic [2:0]      emd_op,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    input  logic [XLEN-1:0] eimm,
    input  logic [XLEN-1:0] epc4,
    input  logic [RW-1:0]   ern0,
    input  logic            ewreg,
    output logic            estall,
    output logic            mvalid,
    output logic            mwreg,
    output logic [RW-1:0]   mrn,
    output logic [XLEN-1:0] malu,
    output logic            md_busy
);

    logic [XLEN-1:0] opa, opb, alu_out, result, hi, lo;
    logic [RW-1:0]   ern;
    logic            md_start;

    logic            mvalid_q, mvalid_d;
    logic            mwreg_q, mwreg_d;
    logic [RW-1:0]   mrn_q, mrn_d;
    logic [XLEN-1:0] malu_q, malu_d;

    pipealu #(.XLEN(XLEN)) u_alu (
        .a    (opa),
        .b    (opb),
        .aluc (ealuc),
        .r    (alu_out)
    );

    pipemdu #(.XLEN(XLEN)) u_mdu (
        .clock  (clock),
        .resetn (resetn),
        .start  (md_start),
        .op     (emd_op),
        .a      (ea),
        .b      (eb),
        .busy   (md_busy),
        .hi     (hi),
        .lo     (lo)
    );

    always_comb begin
        opa      = eshift  ? eimm : ea;
        opb      = ealuimm ? eimm : eb;
        estall   = ein_valid & md_busy & md_is_hazard(emd_op);
        md_start = ein_valid & ~estall & md_is_start(emd_op);
        ern      = ern0 | {RW{ejal}};

        if (ejal)                   result = epc4 + XLEN'(4);
        else if (emd_op == MD_MFHI) result = hi;
        else if (emd_op == MD_MFLO) result = lo;
        else                        result = alu_out;

        mvalid_d = ein_valid;
        mwreg_d  = ein_valid & ewreg;
        mrn_d    = ern;
        malu_d   = result;
        // A stalled instruction stays in EX; MEM sees a bubble with stale data.
        if (estall) begin
            mvalid_d = 1'b0;
            mwreg_d  = 1'b0;
            mrn_d    = mrn_q;
            malu_d   = malu_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mvalid_q <= 1'b0;
            mwreg_q  <= 1'b0;
            mrn_q    <= '0;
            malu_q   <= '0;
        end else begin
            mvalid_q <= mvalid_d;
            mwreg_q  <= mwreg_d;
            mrn_q    <= mrn_d;
            malu_q   <= malu_d;
        end
    end

    assign mvalid = mvalid_q;
    assign mwreg  = mwreg_q;
    assign mrn    = mrn_q;
    assign malu   = malu_q;

endmodule

// File: tb/tb_pipeexe_md.sv
// Table-driven bench for pipeexe_md: each vector is issued, its stall length
// measured, and the EX/MEM result checked against a scoreboard entry.
module tb_pipeexe_md;
    import pipeexe_md_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            ein_valid = 1'b0;
    logic [3:0]      ealuc = ALU_ADD;
    logic            ealuimm = 1'b0, eshift = 1'b0, ejal = 1'b0, ewreg = 1'b0;
    logic [2:0]      emd_op = MD_NONE;
    logic [XLEN-1:0] ea = '0, eb = '0, eimm = '0, epc4 = '0;
    logic [RW-1:0]   ern0 = '0;
    logic            estall, mvalid, mwreg, md_busy;
    logic [RW-1:0]   mrn;
    logic [XLEN-1:0] malu;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipeexe_md #(.XLEN(XLEN), .RW(RW)) dut (
        .clock(clock), .resetn(resetn), .ein_valid(ein_valid), .ealuc(ealuc),
        .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .emd_op(emd_op),
        .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0), .ewreg(ewreg),
        .estall(estall), .mvalid(mvalid), .mwreg(mwreg), .mrn(mrn), .malu(malu),
        .md_busy(md_busy)
    );

    typedef struct {
        logic        v;
        logic [3:0]  aluc;
        logic        aluimm, shift, jal, wreg;
        logic [2:0]  md;
        logic [31:0] a, b, imm, pc4;
        logic [4:0]  rn;
        logic [31:0] exp_alu;
        logic [4:0]  exp_rn;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rn;
        logic        wreg, vld;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(logic v, logic [3:0] aluc, logic aluimm, logic shift,
                                logic jal, logic [2:0] md, logic [31:0] a, logic [31:0] b,
                                logic [31:0] imm, logic [31:0] pc4, logic [4:0] rn,
                                logic wreg, logic [31:0] exp_alu, logic [4:0] exp_rn,
                                int exp_stall);
        vec_t t;
        t.v = v; t.aluc = aluc; t.aluimm = aluimm; t.shift = shift; t.jal = jal;
        t.md = md; t.a = a; t.b = b; t.imm = imm; t.pc4 = pc4; t.rn = rn; t.wreg = wreg;
        t.exp_alu = exp_alu; t.exp_rn = exp_rn; t.exp_stall = exp_stall;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        ein_valid = t.v;    ealuc = t.aluc;  ealuimm = t.aluimm; eshift = t.shift;
        ejal      = t.jal;  emd_op = t.md;   ea = t.a;  eb = t.b; eimm = t.imm;
        epc4      = t.pc4;  ern0 = t.rn;     ewreg = t.wreg;
    endtask

    task automatic run_vec(input string name, input vec_t t);
        int   st;
        exp_t e;
        drive(t);
        #1;
        st = 0;
        while (estall === 1'b1 && st < 200) begin
            @(posedge clock); #1;
            st++;
            chk({name, "_bubble"}, {63'd0, mvalid}, 64'd0);
        end
        chk({name, "_stall"}, 64'(st), 64'(t.exp_stall));
        e.alu = t.exp_alu; e.rn = t.exp_rn; e.wreg = t.v & t.wreg; e.vld = t.v;
        sb.push_back(e);
        @(posedge clock); #1;
        e = sb.pop_front();
        chk({name, "_malu"},   {32'd0, malu},  {32'd0, e.alu});
        chk({name, "_mrn"},    {59'd0, mrn},   {59'd0, e.rn});
        chk({name, "_mwreg"},  {63'd0, mwreg}, {63'd0, e.wreg});
        chk({name, "_mvalid"}, {63'd0, mvalid},{63'd0, e.vld});
    endtask

    initial begin
        //            v  aluc     imm sh jal md        a             b             imm           pc4      rn  wr exp_alu       ern st
        tbl.push_back(mk(1, ALU_ADD, 1, 0, 0, MD_NONE,  32'd5,        32'd0,        32'd7,        32'd0,   8, 1, 32'd12,        8,  0));
        tbl.push_back(mk(1, ALU_SUB, 0, 0, 0, MD_NONE,  32'd10,       32'd3,        32'd0,        32'd0,   3, 1, 32'd7,         3,  0));
        tbl.push_back(mk(1, ALU_AND, 0, 0, 0, MD_NONE,  32'hF0F0,     32'hFF00,     32'd0,        32'd0,   4, 1, 32'hF000,      4,  0));
        tbl.push_back(mk(1, ALU_OR,  0, 0, 0, MD_NONE,  32'hF0F0,     32'hFF00,     32'd0,        32'd0,   5, 1, 32'hFFF0,      5,  0));
        tbl.push_back(mk(1, ALU_XOR, 0, 0, 0, MD_NONE,  32'hF0F0,     32'hFF00,     32'd0,        32'd0,   6, 1, 32'h0FF0,      6,  0));
        tbl.push_back(mk(1, ALU_SLL, 0, 1, 0, MD_NONE,  32'd0,        32'd1,        32'd4,        32'd0,   7, 1, 32'd16,        7,  0));
        tbl.push_back(mk(1, ALU_SRA, 0, 1, 0, MD_NONE,  32'd0,        32'h80000000, 32'd4,        32'd0,   9, 1, 32'hF8000000,  9,  0));
        tbl.push_back(mk(1, ALU_SRL, 0, 1, 0, MD_NONE,  32'd0,        32'h80000000, 32'd4,        32'd0,  10, 1, 32'h08000000, 10,  0));
        tbl.push_back(mk(1, ALU_LUI, 1, 0, 0, MD_NONE,  32'd0,        32'd0,        32'h1234,     32'd0,  11, 1, 32'h12340000, 11,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 1, MD_NONE,  32'd0,        32'd0,        32'd0,        32'h100, 0, 1, 32'h104,      31,  0));
        tbl.push_back(mk(0, ALU_ADD, 0, 0, 0, MD_NONE,  32'd1,        32'd1,        32'd0,        32'd0,  12, 1, 32'd2,        12,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_NONE,  32'd2,        32'd3,        32'd0,        32'd0,  13, 0, 32'd5,        13,  0));
        // -3 * 5 = -15
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MULT,  32'hFFFFFFFD, 32'd5,        32'd0,        32'd0,   0, 0, 32'd2,         0,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFLO,  32'd0,        32'd0,        32'd0,        32'd0,  14, 1, 32'hFFFFFFF1, 14, 33));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFHI,  32'd0,        32'd0,        32'd0,        32'd0,  15, 1, 32'hFFFFFFFF, 15,  0));
        // -7 / 2 = -3 rem -1
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_DIV,   32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,   0, 0, 32'hFFFFFFFB,  0,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFLO,  32'd0,        32'd0,        32'd0,        32'd0,  16, 1, 32'hFFFFFFFD, 16, 33));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFHI,  32'd0,        32'd0,        32'd0,        32'd0,  17, 1, 32'hFFFFFFFF, 17,  0));
        // 9 / 0 unsigned
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_DIVU,  32'd9,        32'd0,        32'd0,        32'd0,   0, 0, 32'd9,         0,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFHI,  32'd0,        32'd0,        32'd0,        32'd0,  18, 1, 32'd9,        18, 33));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFLO,  32'd0,        32'd0,        32'd0,        32'd0,  19, 1, 32'hFFFFFFFF, 19,  0));
        // max unsigned squared, with an independent ADD while busy
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,   0, 0, 32'hFFFFFFFE,  0,  0));
        tbl.push_back(mk(1, ALU_ADD, 1, 0, 0, MD_NONE,  32'd5,        32'd0,        32'd7,        32'd0,  20, 1, 32'd12,       20,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFHI,  32'd0,        32'd0,        32'd0,        32'd0,  21, 1, 32'hFFFFFFFE, 21, 32));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFLO,  32'd0,        32'd0,        32'd0,        32'd0,  22, 1, 32'd1,        22,  0));
        // signed minimum / -1
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,   0, 0, 32'h7FFFFFFF,  0,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFLO,  32'd0,        32'd0,        32'd0,        32'd0,  23, 1, 32'h80000000, 23, 33));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFHI,  32'd0,        32'd0,        32'd0,        32'd0,  24, 1, 32'd0,        24,  0));
        // signed minimum squared = 2^62
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MULT,  32'h80000000, 32'h80000000, 32'd0,        32'd0,   0, 0, 32'd0,         0,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFHI,  32'd0,        32'd0,        32'd0,        32'd0,  25, 1, 32'h40000000, 25, 33));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFLO,  32'd0,        32'd0,        32'd0,        32'd0,  26, 1, 32'd0,        26,  0));
        // 7 / -2 = -3 rem 1
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd0,        32'd0,   0, 0, 32'd5,         0,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFLO,  32'd0,        32'd0,        32'd0,        32'd0,  27, 1, 32'hFFFFFFFD, 27, 33));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFHI,  32'd0,        32'd0,        32'd0,        32'd0,  28, 1, 32'd1,        28,  0));
        // signed -7 / 0
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_DIV,   32'hFFFFFFF9, 32'd0,        32'd0,        32'd0,   0, 0, 32'hFFFFFFF9,  0,  0));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFLO,  32'd0,        32'd0,        32'd0,        32'd0,  29, 1, 32'hFFFFFFFF, 29, 33));
        tbl.push_back(mk(1, ALU_ADD, 0, 0, 0, MD_MFHI,  32'd0,        32'd0,        32'd0,        32'd0,  30, 1, 32'hFFFFFFF9, 30,  0));

        #1;
        chk("rst_mvalid", {63'd0, mvalid},  64'd0);
        chk("rst_mwreg",  {63'd0, mwreg},   64'd0);
        chk("rst_mrn",    {59'd0, mrn},     64'd0);
        chk("rst_malu",   {32'd0, malu},    64'd0);
        chk("rst_busy",   {63'd0, md_busy}, 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of a divide: everything clears before any edge.
        run_vec("div_pre_rst", mk(1, ALU_ADD, 0, 0, 0, MD_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, 32'd107, 0, 0));
        drive(mk(1, ALU_ADD, 0, 0, 0, MD_NONE, 32'd1, 32'd2, 32'd0, 32'd0, 3, 1, 32'd3, 3, 0));
        repeat (9) begin @(posedge clock); #1; end
        chk("pre_rst_busy",   {63'd0, md_busy}, 64'd1);
        chk("pre_rst_mvalid", {63'd0, mvalid},  64'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy",   {63'd0, md_busy}, 64'd0);
        chk("mid_rst_mvalid", {63'd0, mvalid},  64'd0);
        chk("mid_rst_malu",   {32'd0, malu},    64'd0);
        chk("mid_rst_hi",     {32'd0, dut.u_mdu.hi_q}, 64'd0);
        chk("mid_rst_lo",     {32'd0, dut.u_mdu.lo_q}, 64'd0);
        ein_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        run_vec("post_rst_mflo", mk(1, ALU_ADD, 0, 0, 0, MD_MFLO, 32'd0, 32'd0, 32'd0, 32'd0, 1, 1, 32'd0, 1, 0));
        run_vec("post_rst_mfhi", mk(1, ALU_ADD, 0, 0, 0, MD_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 2, 1, 32'd0, 2, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
